rob_multi_cdb: RTL and testbench

- Parametrised reorder buffer, the successor of the single-CDB ROB.
- Depth is 2**ROB_BIT. It accepts NUM_CDB result broadcasts per cycle and tracks occupancy with an explicit counter, so full and empty are never ambiguous.
- Stores retire through a handshake with the LSB. A mispredicted branch at head flushes the whole buffer.
- Sits between the decoder/issue stage, the RS/LSB broadcast buses, and the register file.

---
 rtl/rob_multi_cdb.sv | 222 ++++++++++++++++++++++
 tb/tb_rob_multi_cdb.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_cdb.sv
// Reorder buffer with NUM_CDB completion lanes, store-commit handshake and flush on head mispredict.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle CDB / done-at-issue results to the queries.
module rob_multi_cdb #(
   parameter int ROB_BIT = 4,
   parameter int NUM_CDB = 2
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       rdy_in,
   input  logic                       issue_valid,
   output logic                       issue_ready,
   input  logic [31:0]                issue_pc,
   input  logic [4:0]                 issue_rd,
   input  logic [1:0]                 issue_kind,
   input  logic [31:0]                issue_value,
   input  logic                       issue_pred,
   input  logic [31:0]                issue_target,
   output logic [ROB_BIT-1:0]         issue_tag,
   input  logic [NUM_CDB-1:0]         cdb_valid,
   input  logic [NUM_CDB*ROB_BIT-1:0] cdb_tag,
   input  logic [NUM_CDB*32-1:0]      cdb_value,
   input  logic [ROB_BIT-1:0]         query_tag1,
   input  logic [ROB_BIT-1:0]         query_tag2,
   output logic                       query_ready1,
   output logic                       query_ready2,
   output logic [31:0]                query_value1,
   output logic [31:0]                query_value2,
   output logic                       commit_valid,
   output logic [4:0]                 commit_rd,
   output logic [ROB_BIT-1:0]         commit_tag,
   output logic [31:0]                commit_value,
   output logic                       store_commit_valid,
   input  logic                       store_commit_ack,
   output logic                       flush,
   output logic [31:0]                flush_pc,
   output logic [ROB_BIT:0]           count,
   output logic                       empty,
   output logic                       full
);
   localparam int DEPTH = 1 << ROB_BIT;
   localparam logic [ROB_BIT:0] FULL_CNT = {1'b1, {ROB_BIT{1'b0}}};

   logic [ROB_BIT-1:0] head_q, head_d, tail_q, tail_d;
   logic [ROB_BIT:0]   count_q, count_d;
   logic [DEPTH-1:0]   busy_q, busy_d, done_q, done_d, pred_q, pred_d;
   logic [1:0]         kind_q [DEPTH];
   logic [1:0]         kind_d [DEPTH];
   logic [4:0]         rd_q [DEPTH];
   logic [4:0]         rd_d [DEPTH];
   logic [31:0]        pc_q [DEPTH];
   logic [31:0]        pc_d [DEPTH];
   logic [31:0]        target_q [DEPTH];
   logic [31:0]        target_d [DEPTH];
   logic [31:0]        value_q [DEPTH];
   logic [31:0]        value_d [DEPTH];

   logic [ROB_BIT-1:0] lane_tag [NUM_CDB];
   logic [31:0]        lane_value [NUM_CDB];
   logic               cdb_hit [DEPTH];
   logic [31:0]        cdb_hit_value [DEPTH];
   logic               head_ready, head_taken, pop, issue_fire;

   for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_lane
      assign lane_tag[gi]   = cdb_tag[gi*ROB_BIT +: ROB_BIT];
      assign lane_value[gi] = cdb_value[gi*32 +: 32];
   end

   // Scan lanes high to low so the lowest matching lane is the last writer.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_comb begin
         cdb_hit[gi]       = 1'b0;
         cdb_hit_value[gi] = '0;
         for (int l = NUM_CDB - 1; l >= 0; l--) begin
            if (cdb_valid[l] && lane_tag[l] == ROB_BIT'(gi)) begin
               cdb_hit[gi]       = 1'b1;
               cdb_hit_value[gi] = lane_value[l];
            end
         end
      end
   end

   always_comb begin
      head_ready         = rdy_in && busy_q[head_q] && done_q[head_q];
      head_taken         = value_q[head_q][0];
      commit_valid       = 1'b0;
      store_commit_valid = 1'b0;
      flush              = 1'b0;
      pop                = 1'b0;
      if (head_ready) begin
         case (kind_q[head_q])
            2'd1: begin
               if (head_taken == pred_q[head_q]) pop = 1'b1;
               else flush = 1'b1;
            end
            2'd2: begin
               store_commit_valid = 1'b1;
               pop                = store_commit_ack;
            end
            default: begin
               pop          = 1'b1;
               commit_valid = (rd_q[head_q] != 5'd0);
            end
         endcase
      end
   end

   assign commit_tag   = head_q;
   assign commit_rd    = commit_valid ? rd_q[head_q] : 5'd0;
   assign commit_value = commit_valid ? value_q[head_q] : 32'd0;
   assign flush_pc     = !flush ? 32'd0 : (head_taken ? target_q[head_q] : pc_q[head_q] + 32'd4);
   assign issue_ready  = rdy_in && (count_q != FULL_CNT) && !flush;
   assign issue_fire   = issue_valid && issue_ready;
   assign issue_tag    = tail_q;
   assign count        = count_q;
   assign empty        = (count_q == '0);
   assign full         = (count_q == FULL_CNT);

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pred_d   = pred_q;
      kind_d   = kind_q;
      rd_d     = rd_q;
      pc_d     = pc_q;
      target_d = target_q;
      value_d  = value_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         busy_d  = '0;
         done_d  = '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy_in && cdb_hit[i] && busy_q[i] && !done_q[i] &&
                !(issue_fire && tail_q == ROB_BIT'(i))) begin
               done_d[i]  = 1'b1;
               value_d[i] = cdb_hit_value[i];
            end
         end
         if (issue_fire) begin
            busy_d[tail_q]   = 1'b1;
            done_d[tail_q]   = (issue_kind == 2'd3);
            value_d[tail_q]  = issue_value;
            kind_d[tail_q]   = issue_kind;
            rd_d[tail_q]     = issue_rd;
            pc_d[tail_q]     = issue_pc;
            pred_d[tail_q]   = issue_pred;
            target_d[tail_q] = issue_target;
            tail_d           = tail_q + 1'b1;
         end
         if (pop) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
         end
         count_d = count_q + (ROB_BIT+1)'(issue_fire) - (ROB_BIT+1)'(pop);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         busy_q  <= '0;
         done_q  <= '0;
         pred_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            kind_q[i]   <= '0;
            rd_q[i]     <= '0;
            pc_q[i]     <= '0;
            target_q[i] <= '0;
            value_q[i]  <= '0;
         end
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pred_q   <= pred_d;
         kind_q   <= kind_d;
         rd_q     <= rd_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         value_q  <= value_d;
      end
   end

   logic [ROB_BIT-1:0] q_tag [2];
   logic               q_ready [2];
   logic [31:0]        q_value [2];
   assign q_tag[0] = query_tag1;
   assign q_tag[1] = query_tag2;

   for (genvar gi = 0; gi < 2; gi++) begin : g_query
      always_comb begin
         q_ready[gi] = busy_q[q_tag[gi]] && done_q[q_tag[gi]];
         q_value[gi] = value_q[q_tag[gi]];
`ifdef ROB_CDB_BYPASS_EN
         if (!q_ready[gi]) begin
            if (cdb_hit[q_tag[gi]]) begin
               q_ready[gi] = 1'b1;
               q_value[gi] = cdb_hit_value[q_tag[gi]];
            end else if (issue_fire && issue_kind == 2'd3 && tail_q == q_tag[gi]) begin
               q_ready[gi] = 1'b1;
               q_value[gi] = issue_value;
            end
         end
`endif
      end
   end

   assign query_ready1 = q_ready[0];
   assign query_ready2 = q_ready[1];
   assign query_value1 = q_value[0];
   assign query_value2 = q_value[1];
endmodule

// File: tb/tb_rob_multi_cdb.sv
// Self-checking bench for rob_multi_cdb: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_multi_cdb;
   localparam int RB = 4;
   localparam int NC = 2;
   localparam int DEPTH = 16;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          rdy_in = 1'b1;
   logic          issue_valid = 1'b0;
   logic          issue_ready;
   logic [31:0]   issue_pc = '0;
   logic [4:0]    issue_rd = '0;
   logic [1:0]    issue_kind = '0;
   logic [31:0]   issue_value = '0;
   logic          issue_pred = 1'b0;
   logic [31:0]   issue_target = '0;
   logic [RB-1:0] issue_tag;
   logic [NC-1:0] cdb_valid = '0;
   logic [NC*RB-1:0] cdb_tag = '0;
   logic [NC*32-1:0] cdb_value = '0;
   logic [RB-1:0] query_tag1 = '0, query_tag2 = '0;
   logic          query_ready1, query_ready2;
   logic [31:0]   query_value1, query_value2;
   logic          commit_valid;
   logic [4:0]    commit_rd;
   logic [RB-1:0] commit_tag;
   logic [31:0]   commit_value;
   logic          store_commit_valid;
   logic          store_commit_ack = 1'b0;
   logic          flush;
   logic [31:0]   flush_pc;
   logic [RB:0]   count;
   logic          empty, full;

   always #5 clk_in = ~clk_in;

   rob_multi_cdb #(.ROB_BIT(RB), .NUM_CDB(NC)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_pc(issue_pc),
      .issue_rd(issue_rd), .issue_kind(issue_kind), .issue_value(issue_value),
      .issue_pred(issue_pred), .issue_target(issue_target), .issue_tag(issue_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .query_tag1(query_tag1), .query_tag2(query_tag2),
      .query_ready1(query_ready1), .query_ready2(query_ready2),
      .query_value1(query_value1), .query_value2(query_value2),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_value(commit_value), .store_commit_valid(store_commit_valid),
      .store_commit_ack(store_commit_ack), .flush(flush), .flush_pc(flush_pc),
      .count(count), .empty(empty), .full(full)
   );

   typedef struct {
      int          tag;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [1:0]  kind;
      logic [31:0] value;
      logic        pred;
      logic [31:0] target;
      bit          done;
   } ent_t;

   ent_t mq[$];
   int   m_tail = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int find_tag(int tag);
      foreach (mq[i]) if (mq[i].tag == tag) return i;
      return -1;
   endfunction

   // Reference model: outputs compared at negedge, then state advanced for the coming posedge.
   bit          e_commit, e_store, e_flush, e_ready, e_pop, h_taken;
   logic [31:0] e_fpc;
   bit          claimed [DEPTH];
   int          k, t;
   always @(negedge clk_in) begin
      if (rst_in) begin
         mq.delete();
         m_tail = 0;
      end
      e_commit = 0; e_store = 0; e_flush = 0; e_pop = 0; e_fpc = '0;
      if (rdy_in && !rst_in && mq.size() > 0 && mq[0].done) begin
         h_taken = mq[0].value[0];
         case (mq[0].kind)
            2'd1: begin
               if (h_taken != mq[0].pred) begin
                  e_flush = 1;
                  e_fpc = h_taken ? mq[0].target : mq[0].pc + 32'd4;
               end else e_pop = 1;
            end
            2'd2: begin e_store = 1; e_pop = store_commit_ack; end
            default: begin e_commit = (mq[0].rd != 0); e_pop = 1; end
         endcase
      end
      e_ready = rdy_in && mq.size() < DEPTH && !e_flush;
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("issue_ready", issue_ready, e_ready);
      chk("issue_tag", issue_tag, m_tail);
      chk("commit_tag", commit_tag, (m_tail + DEPTH - mq.size()) % DEPTH);
      chk("commit_valid", commit_valid, e_commit);
      chk("store_commit_valid", store_commit_valid, e_store);
      chk("flush", flush, e_flush);
      if (e_commit) begin
         chk("commit_rd", commit_rd, mq[0].rd);
         chk("commit_value", commit_value, mq[0].value);
      end
      if (e_flush) chk("flush_pc", flush_pc, e_fpc);
      k = find_tag(int'(query_tag1));
      chk("query_ready1", query_ready1, k >= 0 && mq[k].done);
      if (k >= 0 && mq[k].done) chk("query_value1", query_value1, mq[k].value);
      k = find_tag(int'(query_tag2));
      chk("query_ready2", query_ready2, k >= 0 && mq[k].done);
      if (k >= 0 && mq[k].done) chk("query_value2", query_value2, mq[k].value);

      if (!rst_in && rdy_in) begin
         if (e_flush) begin
            mq.delete();
            m_tail = 0;
         end else begin
            foreach (claimed[i]) claimed[i] = 0;
            for (int l = 0; l < NC; l++) begin
               if (cdb_valid[l]) begin
                  t = int'(cdb_tag[l*RB +: RB]);
                  if (!claimed[t]) begin
                     claimed[t] = 1;
                     k = find_tag(t);
                     if (k >= 0 && !mq[k].done) begin
                        mq[k].done = 1;
                        mq[k].value = cdb_value[l*32 +: 32];
                     end
                  end
               end
            end
            if (e_pop) void'(mq.pop_front());
            if (issue_valid && e_ready) begin
               mq.push_back('{tag: m_tail, pc: issue_pc, rd: issue_rd, kind: issue_kind,
                              value: issue_value, pred: issue_pred, target: issue_target,
                              done: (issue_kind == 2'd3)});
               m_tail = (m_tail + 1) % DEPTH;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      rdy_in = 1; issue_valid = 0; cdb_valid = '0; store_commit_ack = 0;
      query_tag1 = '0; query_tag2 = '0;
   endtask

   task automatic set_issue(logic [1:0] kind, logic [4:0] rd, logic [31:0] pc, logic [31:0] val,
                            logic pred, logic [31:0] tgt);
      issue_valid = 1; issue_kind = kind; issue_rd = rd; issue_pc = pc;
      issue_value = val; issue_pred = pred; issue_target = tgt;
   endtask

   task automatic set_lane(int l, int tag, logic [31:0] val);
      cdb_valid[l] = 1'b1;
      cdb_tag[l*RB +: RB] = RB'(tag);
      cdb_value[l*32 +: 32] = val;
   endtask

   task automatic do_reset();
      step();
      idle();
      rst_in = 1;
      @(negedge clk_in);
      step();
      rst_in = 0;
   endtask

   task automatic rand_inputs();
      int r;
      rdy_in = ($urandom_range(0, 9) != 0);
      issue_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 15);
      issue_kind = (r < 8) ? 2'd0 : (r < 10) ? 2'd1 : (r < 13) ? 2'd2 : 2'd3;
      issue_pc = $urandom & 32'hFFFC; issue_rd = 5'($urandom); issue_value = $urandom;
      issue_pred = 1'($urandom); issue_target = $urandom & 32'hFFFC;
      for (int l = 0; l < NC; l++) begin
         cdb_valid[l] = ($urandom_range(0, 2) != 0);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            cdb_tag[l*RB +: RB] = RB'(mq[$urandom_range(0, mq.size() - 1)].tag);
         else
            cdb_tag[l*RB +: RB] = RB'($urandom);
         cdb_value[l*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 4) == 0) cdb_tag[RB +: RB] = cdb_tag[0 +: RB];
      store_commit_ack = ($urandom_range(0, 2) == 0);
      query_tag1 = RB'($urandom);
      query_tag2 = (mq.size() > 0) ? RB'(mq[$urandom_range(0, mq.size() - 1)].tag) : RB'($urandom);
   endtask

   int prev_tag;
   int waited;
   initial begin
      idle();
      #1 rst_in = 1;
      #2;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_full", full, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_flush", flush, 0);
      @(negedge clk_in);
      step();
      rst_in = 0;

      // Fill to capacity, then complete the head.
      for (int i = 0; i < 16; i++) begin
         set_issue(2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 32'hDEAD0000, 1'b0, 32'h0);
         step();
      end
      issue_valid = 0;
      chk("t1_full", full, 1);
      chk("t1_count", count, 16);
      chk("t1_issue_ready", issue_ready, 0);
      set_lane(0, 0, 32'h55);
      step();
      cdb_valid = '0;
      chk("t1_commit_valid", commit_valid, 1);
      chk("t1_commit_rd", commit_rd, 1);
      chk("t1_commit_value", commit_value, 32'h55);
      step();
      chk("t1_count_after", count, 15);

      // Two lanes, different tags; then two lanes on one tag.
      set_lane(0, 3, 32'h33);
      set_lane(1, 5, 32'h35);
      step();
      set_lane(0, 4, 32'hA4);
      set_lane(1, 4, 32'hB4);
      step();
      set_lane(0, 1, 32'h31);
      set_lane(1, 2, 32'h32);
      step();
      cdb_valid = '0;
      chk("t2_head1", commit_value, 32'h31);
      step();
      step();
      chk("t2_tag3_valid", commit_valid, 1);
      chk("t2_tag3", commit_value, 32'h33);
      step();
      chk("t2_tag4_lane0", commit_value, 32'hA4);
      step();
      chk("t2_tag5", commit_value, 32'h35);
      step();
      chk("t2_tag6_wait", commit_valid, 0);
      chk("t2_count", count, 10);
      for (int tg = 6; tg < 16; tg += 2) begin
         set_lane(0, tg, $urandom);
         set_lane(1, tg + 1, $urandom);
         step();
      end
      cdb_valid = '0;
      waited = 0;
      while (!empty && waited < 40) begin step(); waited++; end
      chk("drain_timeout", empty, 1);

      // Mispredicted branch at head flushes everything younger.
      set_issue(2'd1, 5'd0, 32'h100, 32'h0, 1'b0, 32'h200);
      step();
      set_issue(2'd0, 5'd7, 32'h104, 32'h0, 1'b0, 32'h0);
      step();
      step();
      issue_valid = 0;
      set_lane(0, 0, 32'h1);
      step();
      cdb_valid = '0;
      chk("t3_flush", flush, 1);
      chk("t3_flush_pc", flush_pc, 32'h200);
      chk("t3_count_pre", count, 3);
      step();
      chk("t3_count", count, 0);
      chk("t3_empty", empty, 1);
      chk("t3_tail", issue_tag, 0);

      // Store waits at head for the LSB acknowledge.
      set_issue(2'd2, 5'd0, 32'h300, 32'h0, 1'b0, 32'h0);
      step();
      issue_valid = 0;
      set_lane(0, 0, 32'h77);
      step();
      cdb_valid = '0;
      store_commit_ack = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_store_hold", store_commit_valid, 1);
         chk("t4_count_hold", count, 1);
         step();
      end
      store_commit_ack = 1;
      step();
      store_commit_ack = 0;
      chk("t4_popped", count, 0);

      // Continuous issue/complete across the tag wrap.
      prev_tag = 0;
      for (int i = 0; i < 42; i++) begin
         cdb_valid = '0;
         if (i > 0 && i <= 40) set_lane(0, prev_tag, 32'h1000 + 32'(i));
         if (i < 40) begin
            set_issue(2'd0, 5'((i % 31) + 1), 32'h2000 + 32'(4 * i), 32'h0, 1'b0, 32'h0);
            prev_tag = m_tail;
         end else issue_valid = 0;
         query_tag1 = RB'(prev_tag);
         step();
      end
      idle();
      chk("t5_count", count, 0);
      chk("t5_tail_wrap", issue_tag, 9);

      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         step();
      end

      // Asynchronous reset with live entries, then pause behaviour.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         set_issue(2'd0, 5'(i + 1), 32'h4000, 32'h0, 1'b0, 32'h0);
         step();
      end
      issue_valid = 0;
      chk("t6_count7", count, 7);
      #2 rst_in = 1;
      #1;
      chk("t6_async_count", count, 0);
      chk("t6_async_empty", empty, 1);
      @(negedge clk_in);
      step();
      rst_in = 0;
      set_issue(2'd0, 5'd9, 32'h5000, 32'h0, 1'b0, 32'h0);
      step();
      issue_valid = 0;
      set_lane(0, 0, 32'h99);
      step();
      cdb_valid = '0;
      rdy_in = 0;
      set_issue(2'd3, 5'd3, 32'h5004, 32'h1234, 1'b0, 32'h0);
      set_lane(1, 1, 32'h11);
      #1;
      chk("t6_pause_commit", commit_valid, 0);
      chk("t6_pause_ready", issue_ready, 0);
      for (int i = 0; i < 3; i++) step();
      chk("t6_pause_count", count, 1);
      idle();
      #1;
      chk("t6_resume_commit", commit_valid, 1);
      chk("t6_resume_value", commit_value, 32'h99);
      step();
      chk("t6_resume_count", count, 0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
